// File: rtl/sail_write_drain_pkg.sv
// Shared Sail library types for the write drain: the sail_write record,
// the drain FSM states and the request length rule.
package sail_write_drain_pkg;

  localparam int MAX_BYTES_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BYTES = 2'd1,
    ST_TAG   = 2'd2
  } sail_state_e;

  typedef struct packed {
    logic [63:0] paddr;
    logic [7:0]  data;
    logic        is_tag;
  } sail_write_t;

  // A data request must carry between 1 and max_bytes bytes.
  function automatic logic len_ok(input logic [3:0] nbytes, input int max_bytes);
    return (nbytes != 4'd0) && (int'({28'd0, nbytes}) <= max_bytes);
  endfunction

endpackage

// File: rtl/sail_req_fifo.sv
// Request FIFO with valid/ready on both sides; ready is "not full", so a
// full FIFO never accepts a push even if a pop happens in the same cycle.
module sail_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, empty, push, pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

endmodule

// File: rtl/sail_write_drain.sv
// Drains queued write requests into a stream of single-byte or tag
// sail_write records, one record per sink handshake, in acceptance order.
module sail_write_drain
  import sail_write_drain_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_BYTES = MAX_BYTES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [63:0]            req_paddr,
  input  logic [3:0]             req_nbytes,
  input  logic [8*MAX_BYTES-1:0] req_data,
  input  logic                   req_is_tag,
  input  logic                   req_tag,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [63:0]            mem_paddr,
  output logic [7:0]             mem_data,
  output logic                   mem_is_tag,
  output logic                   idle,
  output logic                   err,
  output logic [31:0]            commit_count
);

  localparam int DW = 8 * MAX_BYTES;
  localparam int EW = 64 + 4 + DW + 2;

  logic [EW-1:0] push_entry, pop_entry;
  logic          pop_valid, pop_ready;
  logic [63:0]   pop_paddr;
  logic [3:0]    pop_nbytes;
  logic [DW-1:0] pop_data;
  logic          pop_is_tag, pop_tag;

  sail_state_e   state_q, state_d;
  sail_write_t   rec_q, rec_d;
  logic          mem_valid_q, mem_valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [3:0]    nbytes_q, nbytes_d;
  logic [3:0]    idx_q, idx_d;
  logic          err_q, err_d;
  logic [31:0]   commit_q;
  logic          fire;

  assign push_entry = {req_paddr, req_nbytes, req_data, req_is_tag, req_tag};

  sail_req_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (req_valid),
    .in_ready  (req_ready),
    .in_data   (push_entry),
    .out_valid (pop_valid),
    .out_ready (pop_ready),
    .out_data  (pop_entry)
  );

  assign pop_paddr  = pop_entry[EW-1 -: 64];
  assign pop_nbytes = pop_entry[EW-65 -: 4];
  assign pop_data   = pop_entry[2 +: DW];
  assign pop_is_tag = pop_entry[1];
  assign pop_tag    = pop_entry[0];

  assign fire = mem_valid_q && mem_ready;

  // data_q holds the bytes still to be presented, lowest byte next; the
  // record register only moves on a handshake so a stalled record is held.
  always_comb begin
    state_d     = state_q;
    rec_d       = rec_q;
    mem_valid_d = mem_valid_q;
    data_d      = data_q;
    nbytes_d    = nbytes_q;
    idx_d       = idx_q;
    err_d       = err_q;
    pop_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pop_ready = 1'b1;
        if (pop_valid) begin
          if (pop_is_tag) begin
            state_d      = ST_TAG;
            mem_valid_d  = 1'b1;
            rec_d.paddr  = pop_paddr;
            rec_d.data   = {7'b0, pop_tag};
            rec_d.is_tag = 1'b1;
          end else if (len_ok(pop_nbytes, MAX_BYTES)) begin
            state_d      = ST_BYTES;
            mem_valid_d  = 1'b1;
            rec_d.paddr  = pop_paddr;
            rec_d.data   = pop_data[7:0];
            rec_d.is_tag = 1'b0;
            data_d       = pop_data >> 8;
            nbytes_d     = pop_nbytes;
            idx_d        = 4'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_BYTES: begin
        if (fire) begin
          if (idx_q == nbytes_q - 4'd1) begin
            state_d     = ST_IDLE;
            mem_valid_d = 1'b0;
          end else begin
            idx_d       = idx_q + 4'd1;
            rec_d.paddr = rec_q.paddr + 64'd1;
            rec_d.data  = data_q[7:0];
            data_d      = data_q >> 8;
          end
        end
      end
      ST_TAG: begin
        if (fire) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rec_q       <= '0;
      mem_valid_q <= 1'b0;
      data_q      <= '0;
      nbytes_q    <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      commit_q    <= '0;
    end else begin
      state_q     <= state_d;
      rec_q       <= rec_d;
      mem_valid_q <= mem_valid_d;
      data_q      <= data_d;
      nbytes_q    <= nbytes_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      if (fire) commit_q <= commit_q + 32'd1;
    end
  end

  assign mem_valid    = mem_valid_q;
  assign mem_paddr    = rec_q.paddr;
  assign mem_data     = rec_q.data;
  assign mem_is_tag   = rec_q.is_tag;
  assign idle         = (state_q == ST_IDLE) && !pop_valid;
  assign err          = err_q;
  assign commit_count = commit_q;

endmodule

// File: tb/tb_sail_write_drain.sv
// Randomized and directed bench for sail_write_drain; expected records are
// expanded from each accepted request into a queue and matched in order.
module tb_sail_write_drain;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [63:0] req_paddr;
  logic [3:0]  req_nbytes;
  logic [63:0] req_data;
  logic        req_is_tag, req_tag;
  logic        mem_valid, mem_ready;
  logic [63:0] mem_paddr;
  logic [7:0]  mem_data;
  logic        mem_is_tag, idle, err;
  logic [31:0] commit_count;

  sail_write_drain #(.DEPTH(4), .MAX_BYTES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_paddr(req_paddr),
    .req_nbytes(req_nbytes), .req_data(req_data), .req_is_tag(req_is_tag),
    .req_tag(req_tag), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_paddr(mem_paddr), .mem_data(mem_data), .mem_is_tag(mem_is_tag),
    .idle(idle), .err(err), .commit_count(commit_count)
  );

  typedef struct {
    logic [63:0] paddr;
    logic [7:0]  data;
    logic        isTag;
  } recT;

  recT         expQ[$];
  int          checkCount = 0;
  int          errorCount = 0;
  int          recTotal = 0;
  logic        errExp = 1'b0;
  logic        holdPending = 1'b0;
  logic [63:0] heldPaddr;
  logic [7:0]  heldData;
  logic        heldTag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Expand an accepted request into the records it must produce.
  task automatic modelAccept(input logic [63:0] pa, input logic [3:0] nb, input logic [63:0] d,
                             input logic it, input logic tg);
    recT r;
    if (it) begin
      r.paddr = pa; r.data = {7'b0, tg}; r.isTag = 1'b1;
      expQ.push_back(r);
      recTotal++;
    end else if (nb == 0 || nb > 8) begin
      errExp = 1'b1;
    end else begin
      for (int i = 0; i < int'(nb); i++) begin
        r.paddr = pa + 64'(i); r.data = 8'(d >> (8 * i)); r.isTag = 1'b0;
        expQ.push_back(r);
        recTotal++;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] pa, input logic [3:0] nb,
                               input logic [63:0] d, input logic it, input logic tg,
                               input logic mr, output logic accepted);
    recT e;
    req_valid = v; req_paddr = pa; req_nbytes = nb; req_data = d;
    req_is_tag = it; req_tag = tg; mem_ready = mr;
    #1;
    accepted = v && req_ready;
    if (accepted) modelAccept(pa, nb, d, it, tg);
    if (holdPending) begin
      checkOutput("hold_valid", 64'(mem_valid), 64'd1);
      checkOutput("hold_paddr", mem_paddr, heldPaddr);
      checkOutput("hold_data", 64'(mem_data), 64'(heldData));
      checkOutput("hold_is_tag", 64'(mem_is_tag), 64'(heldTag));
    end
    if (mem_valid && mem_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_record", 64'd1, 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("rec_paddr", mem_paddr, e.paddr);
        checkOutput("rec_data", 64'(mem_data), 64'(e.data));
        checkOutput("rec_is_tag", 64'(mem_is_tag), 64'(e.isTag));
      end
    end
    holdPending = mem_valid && !mem_ready;
    heldPaddr = mem_paddr; heldData = mem_data; heldTag = mem_is_tag;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sendReq(input logic [63:0] pa, input logic [3:0] nb, input logic [63:0] d,
                         input logic it, input logic tg, input logic mr);
    logic acc = 1'b0;
    int   n = 0;
    while (!acc && n < 50) begin
      applyStimulus(1'b1, pa, nb, d, it, tg, mr, acc);
      n++;
    end
    if (!acc) checkOutput("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input int maxCycles, input bit randReady);
    logic acc;
    int   n = 0;
    while (!(idle && expQ.size() == 0) && n < maxCycles) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, randReady ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      n++;
    end
    checkOutput("drain_done", 64'(idle && expQ.size() == 0), 64'd1);
    checkOutput("drain_mem_valid", 64'(mem_valid), 64'd0);
    checkOutput("drain_commit", 64'(commit_count), 64'(recTotal));
    checkOutput("drain_err", 64'(err), 64'(errExp));
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_mem_valid", 64'(mem_valid), 64'd0);
    checkOutput("rst_idle", 64'(idle), 64'd1);
    checkOutput("rst_commit", 64'(commit_count), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_mem_paddr", mem_paddr, 64'd0);
    checkOutput("rst_mem_data", 64'(mem_data), 64'd0);
    checkOutput("rst_mem_is_tag", 64'(mem_is_tag), 64'd0);
    expQ.delete();
    recTotal = 0; errExp = 1'b0; holdPending = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic        acc;
    int          nAcc;
    int          k;
    logic [63:0] pa;
    logic [3:0]  nb;
    req_valid = 0; req_paddr = 0; req_nbytes = 0; req_data = 0;
    req_is_tag = 0; req_tag = 0; mem_ready = 0; rst = 0;
    @(negedge clk);
    doReset();

    // Basic four-byte write and wrap across the top of the address space.
    sendReq(64'h1000, 4'd4, 64'hDDCCBBAA, 1'b0, 1'b0, 1'b1);
    drain(100, 1'b0);
    checkOutput("commit_after_4", 64'(commit_count), 64'd4);
    sendReq(64'hFFFF_FFFF_FFFF_FFFE, 4'd3, 64'h332211, 1'b0, 1'b0, 1'b1);
    drain(100, 1'b0);

    // Fill under back-pressure: four queued plus one held by the FSM.
    doReset();
    nAcc = 0; k = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(k < 6, 64'h2000 + 64'(k * 16), 4'd1, 64'(8'h50 + k), 1'b0, 1'b0, 1'b0, acc);
      if (acc) begin nAcc++; k++; end
    end
    checkOutput("accepted_when_stalled", 64'(nAcc), 64'd5);
    checkOutput("req_ready_full", 64'(req_ready), 64'd0);
    checkOutput("stalled_valid", 64'(mem_valid), 64'd1);
    drain(200, 1'b0);

    // Tag between two data writes.
    sendReq(64'h3000, 4'd2, 64'hB2B1, 1'b0, 1'b0, 1'b1);
    sendReq(64'h40, 4'd0, 64'hFFFF, 1'b1, 1'b1, 1'b1);
    sendReq(64'h3100, 4'd2, 64'hC2C1, 1'b0, 1'b0, 1'b1);
    drain(100, 1'b0);

    // Illegal lengths set a sticky error and emit nothing.
    sendReq(64'h5000, 4'd0, 64'h11, 1'b0, 1'b0, 1'b1);
    sendReq(64'h5100, 4'd9, 64'h22, 1'b0, 1'b0, 1'b1);
    drain(100, 1'b0);
    checkOutput("err_set", 64'(err), 64'd1);
    sendReq(64'h5200, 4'd2, 64'h4433, 1'b0, 1'b0, 1'b1);
    drain(100, 1'b0);
    checkOutput("err_sticky", 64'(err), 64'd1);

    // Reset while byte 2 of an 8-byte request is stalled.
    doReset();
    sendReq(64'h7000, 4'd8, 64'h8877665544332211, 1'b0, 1'b0, 1'b1);
    k = 0;
    while (commit_count < 2 && k < 20) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      k++;
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
    checkOutput("pre_rst_valid", 64'(mem_valid), 64'd1);
    checkOutput("pre_rst_paddr", mem_paddr, 64'h7002);
    doReset();
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      checkOutput("post_rst_quiet", 64'(mem_valid), 64'd0);
    end

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 600; c++) begin
      pa = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7))
                                        : {$urandom, $urandom};
      if ($urandom_range(0, 9) != 0) nb = 4'($urandom_range(1, 8));
      else nb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
      applyStimulus(1'($urandom_range(0, 1)), pa, nb, {$urandom, $urandom},
                    ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), acc);
    end
    drain(2000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/sail_write_drain.md
SAIL_WRITE_DRAIN -- requirements
Module: sail_write_drain

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set request FIFO entries (power of two, >=2).
REQ-002 Parameter MAX_BYTES, default 8, SHALL set maximum bytes per write request.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  1  write request offered.
REQ-006 req_ready  output  1  request accepted when req_valid && req_ready at a clk edge.
REQ-007 req_paddr  input  64  physical base address.
REQ-008 req_nbytes  input  4  byte count, legal 1..MAX_BYTES.
REQ-009 req_data  input  8*MAX_BYTES  data, byte i in bits [8i+7:8i].
REQ-010 req_is_tag  input  1  request is a tag write; req_tag carries the value.
REQ-011 req_tag  input  1  tag value.
REQ-012 mem_valid  output  1  one sail_write record (byte or tag) presented.
REQ-013 mem_ready  input  1  sink consumes the record on mem_valid && mem_ready.
REQ-014 mem_paddr  output  64  record address.
REQ-015 mem_data  output  8  record byte; tag value in bit 0 for tag records.
REQ-016 mem_is_tag  output  1  record is a tag write.
REQ-017 idle  output  1  FIFO empty and FSM in IDLE.
REQ-018 err  output  1  sticky illegal-length flag.
REQ-019 commit_count  output  32  records consumed since reset.

Function
REQ-020 Requests SHALL enter a DEPTH-entry FIFO; req_ready SHALL equal "FIFO not full", with no same-cycle bypass when full.
REQ-021 FSM states IDLE, BYTES, TAG; IDLE -> BYTES on popping a data request, IDLE -> TAG on popping a tag request.
REQ-022 In BYTES the block SHALL emit bytes i = 0..nbytes-1 in ascending order, mem_paddr = paddr + i modulo 2^64, mem_data = data[8i+7:8i].
REQ-023 In TAG the block SHALL emit exactly one record: mem_paddr = paddr, mem_data = {7'b0, tag}, mem_is_tag = 1.
REQ-024 The FIFO pop SHALL occur in the IDLE cycle; the first record SHALL be valid on the following cycle (one-cycle latency from IDLE to mem_valid).
REQ-025 mem_valid, mem_paddr, mem_data and mem_is_tag SHALL stay stable while mem_valid && !mem_ready.
REQ-026 On the last handshake of a request the FSM SHALL return to IDLE; back-to-back requests therefore incur one bubble cycle.
REQ-027 A data request with nbytes = 0 or nbytes > MAX_BYTES SHALL be popped, emit nothing, and set err; tag requests ignore req_nbytes.
REQ-028 commit_count SHALL increment by 1 per mem handshake and wrap modulo 2^32.
REQ-029 Simultaneous FIFO push and pop SHALL both take effect, leaving occupancy unchanged.
REQ-030 Records SHALL leave in request acceptance order; no reordering or merging.

Reset
REQ-031 On rst: FIFO empty, FSM IDLE, byte index 0, mem_valid 0, mem_paddr 0, mem_data 0, mem_is_tag 0, err 0, commit_count 0, req_ready 1, idle 1.
REQ-032 Reset mid-request SHALL discard the in-flight request and all queued requests; no record SHALL be emitted after rst asserts.

Structure
REQ-033 The sail_write record type, MAX_BYTES default and FSM state enum SHALL live in the shared Sail library package.
REQ-034 The request FIFO SHALL be a separate sub-module, sail_req_fifo (parameterised width/depth, valid/ready both sides).

Verification
REQ-035 Write paddr 0x1000, nbytes 4, data 0xDDCCBBAA, mem_ready=1 -> records (0x1000,AA),(0x1001,BB),(0x1002,CC),(0x1003,DD); commit_count=4.
REQ-036 paddr 0xFFFFFFFFFFFFFFFE, nbytes 3, data 0x332211 -> addresses ...FE, ...FF, 0x0 with bytes 11,22,33.
REQ-037 Push 5 requests with mem_ready=0, DEPTH=4 -> req_ready low after 4 accepted plus 1 popped into FSM; outputs held stable; releasing mem_ready drains all in order.
REQ-038 Tag request paddr 0x40, tag 1, between two 2-byte writes -> single record (0x40, 0x01, is_tag=1) in order between them.
REQ-039 nbytes 0 then nbytes 9 -> no records, err=1 and sticky; following legal request drains normally.
REQ-040 Assert rst while byte 2 of an 8-byte request is stalled -> mem_valid drops immediately, idle=1, commit_count=0, nothing emitted after release.
